// File: rtl/taillight_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : taillight_sequencer
// Description : Turn-signal / taillight controller with sequential turn
//               animation, hazard flash and steady brake lamps.
// Revision    : 1.0 - initial release
// ============================================================================
module taillight_sequencer #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r,
    output logic             busy
);

    localparam int c_STEP_W = $clog2(LAMPS + 1);
    localparam logic [c_STEP_W-1:0] c_STEP_MAX = c_STEP_W'(LAMPS);
    localparam logic [c_STEP_W-1:0] c_STEP_ONE = c_STEP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2,
        ST_HAZ   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_STEP_W-1:0] r_step;
    logic [c_STEP_W-1:0] w_step_nxt;
    logic                r_phase;
    logic                w_phase_nxt;
    logic                r_brake_q;
    logic                w_tick;
    logic                w_hreq;
    logic                w_lreq;
    logic                w_rreq;
    logic [LAMPS-1:0]    w_therm;
    logic [LAMPS-1:0]    w_brake_fill;
    logic [LAMPS-1:0]    w_phase_fill;

    generate
        if (TICK_DIV > 1) begin : g_presc
            localparam int c_PRESC_W = $clog2(TICK_DIV);
            localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);
            logic [c_PRESC_W-1:0] r_presc;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_presc <= '0;
                end else if (r_presc == c_PRESC_MAX) begin
                    r_presc <= '0;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            assign w_tick = (r_presc == c_PRESC_MAX);
        end else begin : g_no_presc
            assign w_tick = 1'b1;
        end
    endgenerate

    // A simultaneous left+right request is treated as hazard.
    assign w_hreq = hazard | (left & right);
    assign w_lreq = left & ~right & ~hazard;
    assign w_rreq = right & ~left & ~hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_step    <= '0;
            r_phase   <= 1'b0;
            r_brake_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_phase   <= w_phase_nxt;
            r_brake_q <= brake;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_phase_nxt = r_phase;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hreq) begin
                        w_state_nxt = ST_HAZ;
                        w_phase_nxt = 1'b1;
                    end else if (w_lreq) begin
                        w_state_nxt = ST_LEFT;
                        w_step_nxt  = c_STEP_ONE;
                    end else if (w_rreq) begin
                        w_state_nxt = ST_RIGHT;
                        w_step_nxt  = c_STEP_ONE;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    // Releasing or reversing the stalk never cuts a sweep short.
                    if (w_hreq) begin
                        w_state_nxt = ST_HAZ;
                        w_phase_nxt = 1'b1;
                        w_step_nxt  = '0;
                    end else if (r_step < c_STEP_MAX) begin
                        w_step_nxt  = r_step + 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_step_nxt  = '0;
                    end
                end
                ST_HAZ: begin
                    if (w_hreq) begin
                        w_phase_nxt = ~r_phase;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_phase_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = '0;
                    w_phase_nxt = 1'b0;
                end
            endcase
        end
    end

    // Shifting all-ones left by step and inverting yields step low bits set.
    assign w_therm      = ~({LAMPS{1'b1}} << r_step);
    assign w_brake_fill = {LAMPS{r_brake_q}};
    assign w_phase_fill = {LAMPS{r_phase}};

    always_comb begin
        lamp_l = '0;
        lamp_r = '0;
        case (r_state)
            ST_IDLE: begin
                lamp_l = w_brake_fill;
                lamp_r = w_brake_fill;
            end
            ST_LEFT: begin
                lamp_l = w_therm;
                lamp_r = w_brake_fill;
            end
            ST_RIGHT: begin
                lamp_l = w_brake_fill;
                lamp_r = w_therm;
            end
            ST_HAZ: begin
                lamp_l = w_phase_fill;
                lamp_r = w_phase_fill;
            end
            default: begin
                lamp_l = '0;
                lamp_r = '0;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
